irq_controller: RTL and testbench

- Parametrised interrupt controller for NUM_IRQ sources. It replaces the four fixed CPU interrupt lines (timers, UART RX, frameDrawn) with a single prioritised request/acknowledge interface.
- Synchronises each source, then applies per-channel edge/level mode and masking.
- Latches pending edges and presents the highest-priority ID to the CPU.
- Sits between the peripherals/MemoryUnit and the CPU. Configured through a small register port driven by the MemoryUnit.

---
 rtl/irq_controller.sv | 166 ++++++++++++++++
 tb/tb_irq_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: per-source synchroniser and edge detect, edge/level
// pending logic with masking, and a REQ/ACK/EOI handshake toward the CPU.

module irq_sync_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   s_d;

    // rise is registered so that pending lands one edge after the edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            s_d   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain[0] <= irq;
            for (int j = 1; j < SYNC_STAGES; j++) chain[j] <= chain[j-1];
            s_d  <= chain[SYNC_STAGES-1];
            rise <= chain[SYNC_STAGES-1] & ~s_d;
        end
    end

    assign s = chain[SYNC_STAGES-1];
endmodule

module irq_controller #(
    parameter int                 NUM_IRQ     = 8,
    parameter int                 IDW         = 3,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] RESET_MODE  = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [1:0]         reg_addr,
    input  logic               reg_we,
    input  logic [NUM_IRQ-1:0] reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               int_req,
    output logic [IDW-1:0]     int_id,
    input  logic               int_ack,
    input  logic               int_eoi
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]         state;
    logic [NUM_IRQ-1:0] s, rise;
    logic [NUM_IRQ-1:0] mask_q, mode_q, pend_q;
    logic [NUM_IRQ-1:0] mode_d, pend_d, clr;
    logic [NUM_IRQ-1:0] pending, eligible, id_oh;
    logic [IDW-1:0]     sel_id, in_service_id;
    logic               wr_mask, wr_mode, wr_pend, ack_fire, drop;
    logic [7+IDW:0]     status_w;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
        irq_sync_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[g]),
            .s     (s[g]),
            .rise  (rise[g])
        );
    end

    // Level channels bypass pend_q entirely; pend_q is held at zero for them.
    assign pending  = (pend_q & mode_q) | (s & ~mode_q);
    assign eligible = pending & mask_q;
    assign id_oh    = NUM_IRQ'(1) << int_id;

    assign wr_mask  = reg_we && (reg_addr == 2'd0);
    assign wr_mode  = reg_we && (reg_addr == 2'd1);
    assign wr_pend  = reg_we && (reg_addr == 2'd2);
    assign ack_fire = (state == REQ) && int_ack;

    // Request is withdrawn if its channel gets masked or its level source goes away.
    assign drop = !(|(id_oh & mask_q)) || (|(id_oh & ~mode_q & ~s));

    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = IDW'(i);
        end
    end

    // Sets take priority over clears; bits entering edge mode start cleared and only
    // see rises detected while already in edge mode.
    always_comb begin
        mode_d = wr_mode ? reg_wdata : mode_q;
        clr    = '0;
        if (wr_pend)  clr = clr | reg_wdata;
        if (ack_fire) clr = clr | id_oh;
        pend_d = ((pend_q & ~clr) | (rise & mode_q)) & mode_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            mode_q <= RESET_MODE;
            pend_q <= '0;
        end else begin
            if (wr_mask) mask_q <= reg_wdata;
            mode_q <= mode_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            int_req       <= 1'b0;
            int_id        <= '0;
            in_service_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        int_id  <= sel_id;
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req       <= 1'b0;
                        in_service_id <= int_id;
                        state         <= SERVICE;
                    end else if (drop) begin
                        int_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SERVICE: begin
                    if (int_eoi) state <= IDLE;
                end
                default: begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign status_w = {in_service_id, 6'b0, state == SERVICE, int_req};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_rdata <= '0;
        end else begin
            case (reg_addr)
                2'd0:    reg_rdata <= 32'(mask_q);
                2'd1:    reg_rdata <= 32'(mode_q);
                2'd2:    reg_rdata <= 32'(pending);
                default: reg_rdata <= 32'(status_w);
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed handshake scenarios plus randomized edge bursts
// checked against a sequence-level model of pending and priority.

module tb_irq_controller;
    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  irq_in = '0;
    logic [1:0]    reg_addr = '0;
    logic          reg_we = 1'b0;
    logic [N-1:0]  reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          int_req;
    logic [IDW-1:0] int_id;
    logic          int_ack = 1'b0;
    logic          int_eoi = 1'b0;

    int tests = 0;
    int fails = 0;

    irq_controller #(.NUM_IRQ(N), .IDW(IDW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .reg_addr(reg_addr),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .int_req(int_req), .int_id(int_id), .int_ack(int_ack), .int_eoi(int_eoi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [N-1:0] v);
        reg_addr = a; reg_wdata = v; reg_we = 1'b1;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        tick();
        d = reg_rdata;
    endtask

    task automatic pulse(input int ch);
        irq_in[ch] = 1'b1;
        tick();
        irq_in[ch] = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic eoi();
        int_eoi = 1'b1; tick(); int_eoi = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int n;
        tests++;
        if (int_req !== 1'b0 || int_id !== '0 || reg_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_initial: req=%b id=%0d rdata=%0h want 0", int_req, int_id, reg_rdata);
        end
        tick(); reset = 1'b0; tick();
        wr(2'd3, 8'hFF);
        rd(2'd3, d);
        tests++;
        if (d !== 32'd0) begin
            fails++; $display("FAIL status_write_ignored: got %0h want 0", d);
        end
        wr(2'd1, 8'hFE);
        wr(2'd0, 8'hFF);
        pulse(5);
        for (n = 0; n < 20 && !int_req; n++) tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd5) begin
            fails++; $display("FAIL reset_setup_req: req=%b id=%0d want 1/5", int_req, int_id);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (int_req !== 1'b0 || int_id !== '0 || reg_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_async: req=%b id=%0d rdata=%0h want 0/0/0", int_req, int_id, reg_rdata);
        end
        @(posedge clk); #1; reset = 1'b0;
        rd(2'd0, d);
        tests++;
        if (d !== 32'h00) begin fails++; $display("FAIL reset_mask: got %0h want 00", d); end
        rd(2'd1, d);
        tests++;
        if (d !== 32'hFF) begin fails++; $display("FAIL reset_mode: got %0h want ff", d); end
        rd(2'd2, d);
        tests++;
        if (d !== 32'h00) begin fails++; $display("FAIL reset_pend: got %0h want 00", d); end
    endtask

    task automatic test_single_edge();
        logic [31:0] d;
        int n;
        wr(2'd0, 8'hFF);
        pulse(5);
        for (n = 0; n < 12 && !int_req; n++) tick();
        tests++;
        if (n !== SS + 2 || int_id !== 3'd5) begin
            fails++; $display("FAIL edge_latency: edges=%0d id=%0d want %0d/5", n, int_id, SS + 2);
        end
        ack();
        tests++;
        if (int_req !== 1'b0) begin fails++; $display("FAIL ack_drops_req: req=%b want 0", int_req); end
        rd(2'd2, d);
        tests++;
        if (d !== 32'h00) begin fails++; $display("FAIL ack_clears_pend: got %0h want 00", d); end
        rd(2'd3, d);
        tests++;
        if (d !== 32'h0502) begin fails++; $display("FAIL status_service: got %0h want 502", d); end
        eoi();
        rd(2'd3, d);
        tests++;
        if (d[1] !== 1'b0) begin fails++; $display("FAIL eoi_status: got %0h want bit1=0", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        int n;
        pulse(6);
        for (n = 0; n < 12 && !int_req; n++) tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd6) begin
            fails++; $display("FAIL prio_first: req=%b id=%0d want 1/6", int_req, int_id);
        end
        pulse(1);
        repeat (SS + 4) tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd6) begin
            fails++; $display("FAIL prio_frozen: req=%b id=%0d want 1/6", int_req, int_id);
        end
        ack();
        rd(2'd2, d);
        tests++;
        if (d !== 32'h02) begin fails++; $display("FAIL prio_pend: got %0h want 02", d); end
        eoi();
        for (n = 0; n < 6 && !int_req; n++) tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd1 || n !== 1) begin
            fails++; $display("FAIL prio_next: req=%b id=%0d delay=%0d want 1/1/1", int_req, int_id, n);
        end
        ack(); eoi();
    endtask

    task automatic test_masking();
        logic [31:0] d;
        wr(2'd0, 8'h00);
        pulse(3);
        repeat (SS + 4) tick();
        tests++;
        if (int_req !== 1'b0) begin fails++; $display("FAIL mask_no_req: req=%b want 0", int_req); end
        rd(2'd2, d);
        tests++;
        if (d !== 32'h08) begin fails++; $display("FAIL mask_pend: got %0h want 08", d); end
        wr(2'd0, 8'h08);
        tests++;
        if (int_req !== 1'b0) begin fails++; $display("FAIL unmask_early: req=%b want 0", int_req); end
        tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd3) begin
            fails++; $display("FAIL unmask_req: req=%b id=%0d want 1/3", int_req, int_id);
        end
        wr(2'd2, 8'h08);
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd3) begin
            fails++; $display("FAIL w1c_frozen: req=%b id=%0d want 1/3", int_req, int_id);
        end
        ack();
        rd(2'd2, d);
        tests++;
        if (d !== 32'h00) begin fails++; $display("FAIL w1c_ack_pend: got %0h want 00", d); end
        eoi();
        wr(2'd0, 8'hFF);
    endtask

    task automatic test_level();
        logic [31:0] d;
        int n;
        wr(2'd1, 8'hFE);
        irq_in[0] = 1'b1;
        for (n = 0; n < 12 && !int_req; n++) tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd0) begin
            fails++; $display("FAIL level_req: req=%b id=%0d want 1/0", int_req, int_id);
        end
        ack();
        tick();
        eoi();
        tick();
        tests++;
        if (int_req !== 1'b1 || int_id !== 3'd0) begin
            fails++; $display("FAIL level_rereq: req=%b id=%0d want 1/0", int_req, int_id);
        end
        irq_in[0] = 1'b0;
        for (n = 0; n < 8 && int_req; n++) tick();
        rd(2'd3, d);
        tests++;
        if (int_req !== 1'b0 || d[1:0] !== 2'b00) begin
            fails++; $display("FAIL level_drop: req=%b status=%0h want 0/idle", int_req, d);
        end
        wr(2'd1, 8'hFF);
        rd(2'd2, d);
        tests++;
        if (d !== 32'h00) begin fails++; $display("FAIL level_to_edge_pend: got %0h want 00", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        wr(2'd0, 8'h00);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        repeat (SS) tick();
        wr(2'd2, 8'h04);
        rd(2'd2, d);
        tests++;
        if (d[2] !== 1'b1) begin fails++; $display("FAIL collision_set_wins: got %0h want bit2=1", d); end
        wr(2'd2, 8'h04);
        rd(2'd2, d);
        tests++;
        if (d !== 32'h00) begin fails++; $display("FAIL w1c_clears: got %0h want 00", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [N-1:0] seq [6];
        logic [N-1:0] exp, prev, m, el;
        int id;
        for (int it = 0; it < 24; it++) begin
            wr(2'd0, 8'h00);
            irq_in = '0;
            repeat (SS + 3) tick();
            wr(2'd2, 8'hFF);
            for (int k = 0; k < 6; k++) begin
                seq[k] = N'($urandom);
                irq_in = seq[k];
                tick();
            end
            irq_in = '0;
            repeat (SS + 3) tick();
            exp = '0; prev = '0;
            for (int k = 0; k < 6; k++) begin
                exp = exp | (seq[k] & ~prev);
                prev = seq[k];
            end
            rd(2'd2, d);
            tests++;
            if (d !== 32'(exp)) begin fails++; $display("FAIL rand_pend[%0d]: got %0h want %0h", it, d, exp); end
            m = N'($urandom);
            el = exp & m;
            id = -1;
            for (int i = N - 1; i >= 0; i--) if (el[i]) id = i;
            wr(2'd0, m);
            tick();
            tests++;
            if (id < 0) begin
                if (int_req !== 1'b0) begin fails++; $display("FAIL rand_noreq[%0d]: req=%b want 0", it, int_req); end
            end else begin
                if (int_req !== 1'b1 || int_id !== IDW'(id)) begin
                    fails++; $display("FAIL rand_req[%0d]: req=%b id=%0d want 1/%0d", it, int_req, int_id, id);
                end
                ack();
                rd(2'd2, d);
                tests++;
                if (d !== 32'(exp & ~(N'(1) << id))) begin
                    fails++; $display("FAIL rand_ack_pend[%0d]: got %0h want %0h", it, d, exp & ~(N'(1) << id));
                end
                eoi();
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_edge();
        test_priority();
        test_masking();
        test_level();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
